// File: rtl/pipe_credit_ctrl.sv
`default_nettype none
// pipe_credit_ctrl: credit-based admission control for fixed-latency, non-stallable pipelines
// feeding an output FIFO; tracks sample position within blocks and generates FIFO strobes.
module pipe_credit_ctrl #(
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BLK_SIZE   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        pipe_en,
  output logic                        pipe_sob,
  output logic                        pipe_eob,
  output logic [$clog2(BLK_SIZE)-1:0] pipe_idx,
  output logic                        fifo_push,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        fifo_pop,
  output logic                        blk_done,
  output logic                        err_ovf
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(BLK_SIZE);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST    = IW'(BLK_SIZE - 1);

  logic [LATENCY-1:0] vchain;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      occ;
  logic [CW:0]        total;
  logic [IW-1:0]      in_idx;
  logic [IW-1:0]      out_idx;
  logic               ovf;

  // Credits are counted from registered state only, so in_ready never depends on out_ready/in_valid.
  assign total     = {1'b0, inflight} + {1'b0, occ};
  assign in_ready  = rst_n & (total < DEPTH_W);
  assign pipe_en   = in_valid & in_ready;
  assign pipe_idx  = rst_n ? in_idx : '0;
  assign pipe_sob  = pipe_en & (in_idx == '0);
  assign pipe_eob  = pipe_en & (in_idx == LAST);
  assign fifo_push = rst_n & vchain[LATENCY-1];
  assign out_valid = rst_n & (occ != '0);
  assign fifo_pop  = out_valid & out_ready;
  assign blk_done  = fifo_pop & (out_idx == LAST);
  assign err_ovf   = rst_n & ovf;

  generate
    if (LATENCY == 1) begin : g_chain_single
      always_ff @(posedge clk) begin
        if (!rst_n) vchain <= '0;
        else        vchain <= pipe_en;
      end
    end else begin : g_chain_multi
      always_ff @(posedge clk) begin
        if (!rst_n) vchain <= '0;
        else        vchain <= {vchain[LATENCY-2:0], pipe_en};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
      occ      <= '0;
      in_idx   <= '0;
      out_idx  <= '0;
      ovf      <= 1'b0;
    end else begin
      inflight <= inflight + CW'(pipe_en) - CW'(fifo_push);
      occ      <= occ + CW'(fifo_push) - CW'(fifo_pop);
      if (pipe_en)  in_idx  <= in_idx + IW'(1);
      if (fifo_pop) out_idx <= out_idx + IW'(1);
      if (fifo_push && (occ == FULL) && !fifo_pop) ovf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_credit_ctrl.sv
`default_nettype none
// tb_pipe_credit_ctrl: directed scenarios plus a cycle-level reference model for two
// configurations (LATENCY=8 with FIFO_DEPTH=16 and FIFO_DEPTH=4).
module tb_pipe_credit_ctrl;
  localparam int LAT  = 8;
  localparam int FD   = 16;
  localparam int FD2  = 4;
  localparam int BLK  = 64;
  localparam int NCYC = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic one = 1'b1;

  logic       in_ready, pipe_en, pipe_sob, pipe_eob, fifo_push, out_valid, fifo_pop, blk_done, err_ovf;
  logic [5:0] pipe_idx;
  logic       in_ready2, pipe_en2, pipe_sob2, pipe_eob2, fifo_push2, out_valid2, fifo_pop2, blk_done2, err_ovf2;
  logic [5:0] pipe_idx2;

  pipe_credit_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(FD), .BLK_SIZE(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pipe_en(pipe_en), .pipe_sob(pipe_sob), .pipe_eob(pipe_eob), .pipe_idx(pipe_idx),
    .fifo_push(fifo_push), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_pop(fifo_pop), .blk_done(blk_done), .err_ovf(err_ovf)
  );

  pipe_credit_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(FD2), .BLK_SIZE(BLK)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(one), .in_ready(in_ready2),
    .pipe_en(pipe_en2), .pipe_sob(pipe_sob2), .pipe_eob(pipe_eob2), .pipe_idx(pipe_idx2),
    .fifo_push(fifo_push2), .out_valid(out_valid2), .out_ready(one),
    .fifo_pop(fifo_pop2), .blk_done(blk_done2), .err_ovf(err_ovf2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model state (next-edge values) and observed event history.
  int cyc = 0;
  logic [LAT-1:0] m_hist = '0;
  int m_infl = 0, m_occ = 0, m_iidx = 0, m_oidx = 0;
  logic [LAT-1:0] m2_hist = '0;
  int m2_infl = 0, m2_occ = 0, m2_iidx = 0, m2_oidx = 0;
  bit rdy_h[NCYC];
  bit en_h[NCYC];
  bit pop_h[NCYC];
  int n_en = 0, n_push = 0, n_pop = 0, n_done = 0, n_en2 = 0;
  int en_cyc[$];
  int push_cyc[$];
  int sob_at[$];
  int eob_at[$];

  always @(negedge clk) begin : p_mon
    logic e_rdy, e_en, e_push, e_val, e_pop;
    if (!rst_n) begin
      check("reset_outs", {in_ready, pipe_en, pipe_sob, pipe_eob, pipe_idx, fifo_push,
                           out_valid, fifo_pop, blk_done, err_ovf}, '0);
      check("reset_outs2", {in_ready2, pipe_en2, pipe_sob2, pipe_eob2, pipe_idx2, fifo_push2,
                            out_valid2, fifo_pop2, blk_done2, err_ovf2}, '0);
      m_hist <= '0;  m_infl <= 0;  m_occ <= 0;  m_iidx <= 0;  m_oidx <= 0;
      m2_hist <= '0; m2_infl <= 0; m2_occ <= 0; m2_iidx <= 0; m2_oidx <= 0;
    end else begin
      e_rdy  = (m_infl + m_occ) < FD;
      e_en   = in_valid & e_rdy;
      e_push = m_hist[LAT-1];
      e_val  = (m_occ != 0);
      e_pop  = e_val & out_ready;
      check("cycle", {in_ready, pipe_en, pipe_sob, pipe_eob, pipe_idx, fifo_push,
                      out_valid, fifo_pop, blk_done, err_ovf},
                     {e_rdy, e_en, e_en && (m_iidx == 0), e_en && (m_iidx == BLK - 1), 6'(m_iidx),
                      e_push, e_val, e_pop, e_pop && (m_oidx == BLK - 1), 1'b0});
      m_hist <= {m_hist[LAT-2:0], e_en};
      m_infl <= m_infl + int'(e_en) - int'(e_push);
      m_occ  <= m_occ + int'(e_push) - int'(e_pop);
      if (e_en)  m_iidx <= (m_iidx + 1) % BLK;
      if (e_pop) m_oidx <= (m_oidx + 1) % BLK;

      e_rdy  = (m2_infl + m2_occ) < FD2;
      e_en   = e_rdy;
      e_push = m2_hist[LAT-1];
      e_val  = (m2_occ != 0);
      e_pop  = e_val;
      check("cycle2", {in_ready2, pipe_en2, pipe_sob2, pipe_eob2, pipe_idx2, fifo_push2,
                       out_valid2, fifo_pop2, blk_done2, err_ovf2},
                      {e_rdy, e_en, e_en && (m2_iidx == 0), e_en && (m2_iidx == BLK - 1), 6'(m2_iidx),
                       e_push, e_val, e_pop, e_pop && (m2_oidx == BLK - 1), 1'b0});
      m2_hist <= {m2_hist[LAT-2:0], e_en};
      m2_infl <= m2_infl + int'(e_en) - int'(e_push);
      m2_occ  <= m2_occ + int'(e_push) - int'(e_pop);
      if (e_en)  m2_iidx <= (m2_iidx + 1) % BLK;
      if (e_pop) m2_oidx <= (m2_oidx + 1) % BLK;
    end
    if (cyc < NCYC) begin
      rdy_h[cyc] <= in_ready;
      en_h[cyc]  <= pipe_en;
      pop_h[cyc] <= fifo_pop;
    end
    if (pipe_en) begin
      n_en <= n_en + 1;
      en_cyc.push_back(cyc);
      if (pipe_sob) sob_at.push_back(n_en);
      if (pipe_eob) eob_at.push_back(n_en);
    end
    if (fifo_push) begin
      n_push <= n_push + 1;
      push_cyc.push_back(cyc);
    end
    if (fifo_pop) n_pop  <= n_pop + 1;
    if (blk_done) n_done <= n_done + 1;
    if (pipe_en2) n_en2  <= n_en2 + 1;
    cyc <= cyc + 1;
  end

  initial begin
    int b_en, b_push, b_pop, b_done, b_ec, b_pc, b_sob, b_eob, b_en2, p;

    // Reset with both handshake inputs high: every output must stay low.
    in_valid = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Stream 128 samples with the consumer always ready.
    p = cyc; b_en = n_en; b_pop = n_pop; b_done = n_done;
    b_ec = en_cyc.size(); b_pc = push_cyc.size(); b_sob = sob_at.size(); b_eob = eob_at.size();
    step(128);
    in_valid = 1'b0;
    step(30);
    check("first_ready", rdy_h[p], 1'b1);
    check("stream_en", n_en - b_en, 128);
    check("sob_count", sob_at.size() - b_sob, 2);
    check("sob0", sob_at[b_sob] - b_en, 0);
    check("sob1", sob_at[b_sob + 1] - b_en, 64);
    check("eob_count", eob_at.size() - b_eob, 2);
    check("eob0", eob_at[b_eob] - b_en, 63);
    check("eob1", eob_at[b_eob + 1] - b_en, 127);
    check("first_push_lat", push_cyc[b_pc] - en_cyc[b_ec], LAT);
    check("stream_pops", n_pop - b_pop, 128);
    check("stream_blk_done", n_done - b_done, 2);

    // Consumer stalled: exactly FIFO_DEPTH admissions, then backpressure.
    out_ready = 1'b0; in_valid = 1'b1;
    b_en = n_en; b_push = n_push;
    step(30);
    check("full_en", n_en - b_en, FD);
    check("full_push", n_push - b_push, FD);
    check("full_ready", in_ready, 1'b0);
    check("full_valid", out_valid, 1'b1);
    check("full_ovf", err_ovf, 1'b0);

    // One-cycle pop frees exactly one credit, visible the following cycle.
    p = cyc; b_pop = n_pop; b_en = n_en;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(12);
    check("pulse_pop", pop_h[p], 1'b1);
    check("pulse_rdy_t", rdy_h[p], 1'b0);
    check("pulse_rdy_t1", rdy_h[p + 1], 1'b1);
    check("pulse_en_t1", en_h[p + 1], 1'b1);
    check("pulse_rdy_t2", rdy_h[p + 2], 1'b0);
    check("pulse_pops", n_pop - b_pop, 1);
    check("pulse_admits", n_en - b_en, 1);

    // Reset with 5 samples in flight and 3 buffered.
    rst_n = 1'b0; in_valid = 1'b0;
    step(1);
    rst_n = 1'b1; in_valid = 1'b1;
    b_push = n_push;
    step(8);
    in_valid = 1'b0;
    step(3);
    check("pre_rst_buffered", n_push - b_push, 3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    p = cyc; b_en = n_en; b_push = n_push; b_pc = push_cyc.size(); b_sob = sob_at.size();
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(20);
    check("post_rst_ready", rdy_h[p], 1'b1);
    check("post_rst_en", en_h[p], 1'b1);
    check("post_rst_sob", sob_at.size() - b_sob, 1);
    check("post_rst_sob_pos", sob_at[b_sob], b_en);
    check("post_rst_pushes", n_push - b_push, 1);
    check("post_rst_push_cyc", push_cyc[b_pc], p + LAT);

    // Random handshakes; the shallow instance runs saturated alongside.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    b_en = n_en; b_push = n_push; b_pop = n_pop; b_done = n_done; b_en2 = n_en2;
    for (int i = 0; i < 10000; i++) begin
      if (i == 20) b_en2 = n_en2;
      // Credit round trip is LATENCY+2 cycles: push, pop a cycle later, credit visible the next.
      if (i == 120) check("shallow_rate", n_en2 - b_en2, 40);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(40);
    check("rand_push_eq_en", n_push - b_push, n_en - b_en);
    check("rand_pop_eq_push", n_pop - b_pop, n_push - b_push);
    check("rand_blk_done", n_done - b_done, (n_pop - b_pop) / BLK);
    check("rand_drained", out_valid, 1'b0);
    check("rand_ovf", err_ovf, 1'b0);
    check("shallow_ovf", err_ovf2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
